mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported main memory between two cache requesters: port 0 is the I-cache and port 1 is the D-cache.
- Each cache drives one-cycle Read/Write request pulses on its cm_ interface. The arbiter latches each pulse in a per-port slot, arbitrates between the ports, and sequences one memory transaction at a time.
- Read data returns to the owning cache as a one-cycle ReadReady pulse.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.

Ports:
- CLK  in  1  clock.
- Reset_n  in  1  async active-low reset.
- pN_ReadValid  in  1  read request pulse from cache N (N = 0, 1).
- pN_ReadAddr  in  ADDR_W  read address, sampled with ReadValid.
- pN_WriteValid  in  1  write request pulse.
- pN_WriteAddr  in  ADDR_W  write address.
- pN_WriteData  in  DATA_W  write data.
- pN_ReadReady  out  1  one-cycle pulse: pN_ReadData is valid.
- pN_ReadData  out  DATA_W  read data, registered, held until the next pN_ReadReady.
- pN_Busy  out  1  port N has any pending slot.
- mem_Req  out  1  memory request, held until mem_Ack.
- mem_RW  out  1  0 = read, 1 = write.
- mem_Addr  out  ADDR_W  memory address.
- mem_WriteData  out  DATA_W  memory write data.
- mem_Ack  in  1  memory completes the current request.
- mem_ReadData  in  DATA_W  valid with mem_Ack on reads.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All outputs go to 0: pN_ReadReady, pN_ReadData, pN_Busy, mem_Req, mem_RW, mem_Addr, mem_WriteData.
  - All slots clear, FSM goes to IDLE, RR pointer goes to 0.
  - Reset mid-transaction drops mem_Req immediately; memory must discard the in-flight op. No ReadReady is produced for an aborted read.
- Per-port slots: rd_pend/rd_addr and wr_pend/wr_addr/wr_data.
  - A Valid pulse is captured at the clock edge only if pN_Busy = 0.
  - Read and write pulses in the same cycle are both captured.
  - Any pulse while Busy = 1 is dropped. This is a protocol violation; the bench asserts it never happens.
- pN_Busy = rd_pend | wr_pend (registered).
- Intra-port order: if both slots are pending, the write issues first. This keeps writeback before refill, so a read of the same address returns the new data.
- Inter-port arbitration is round-robin:
  - If both ports are pending, grant the port != last_grant.
  - last_grant updates when a transaction completes.
- FSM:
  - IDLE: if any slot is pending, select port and op, register mem_Req = 1 plus mem_RW/mem_Addr/mem_WriteData, go to BUSY. Otherwise stay in IDLE.
  - BUSY: hold mem_ outputs stable. On mem_Ack, drop mem_Req and clear the granted slot. For a read, capture mem_ReadData into pN_ReadData. Go to RESP.
  - RESP: for a read, pulse pN_ReadReady for exactly one cycle. Update last_grant. Go to IDLE.
- Latency:
  - Pulse in cycle T.
  - Slot valid and FSM selects in T+1.
  - mem_Req high in T+2.
  - If mem_Ack arrives in T+2, ReadReady pulses in T+4.
  - Minimum 4 cycles per read; back-to-back transactions are spaced 3 cycles apart.
- mem_Ack is allowed in the same cycle mem_Req first rises. mem_Ack outside BUSY is ignored.
- mem_Ack stall: any number of cycles. mem_Req and all mem_ fields stay constant during the stall.
- Writes produce no ReadReady. A port's Busy falls in the cycle after its last slot clears.

Optional Feature:
- ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, port 1 (D-cache) always wins when both ports are pending. last_grant is removed.
  - Undefined: round-robin as described above.
  - Intra-port write-first ordering is unchanged in both modes.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encodings: IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10.
  - MEM_RD = 1'b0, MEM_WR = 1'b1.
  - Port index constants: PORT_I = 0, PORT_D = 1.
- Sub-module arb_req_slot:
  - One per port.
  - Holds the rd/wr pending registers, performs capture gated by Busy, and clears on a grant+ack strobe.
  - Outputs rd_pend, wr_pend, the address/data fields, and Busy.
  - The top level holds the FSM, arbiter, mem_ drivers and response registers.

Test Plan:
- Single read: p0_ReadValid pulse with addr 0x0000_0040; memory acks 1 cycle after Req with 0xDEAD_BEEF -> mem_Req/mem_RW = 0/mem_Addr = 0x40 in T+2, p0_ReadReady pulse with 0xDEAD_BEEF, p0_Busy falls.
- Contention: both ports pulse reads in the same cycle (addr 0x100, 0x200), pointer = 0 -> port 1 served first, then port 0. Each gets the correct data, and each ReadReady pulses exactly once.
- Writeback + refill: p1 WriteValid (0x300, 0x1234_5678) and ReadValid (0x300) in the same cycle, with memory modelled as RAM -> write issues first, and the read returns 0x1234_5678.
- Ack stall: mem_Ack delayed 7 cycles -> mem_Req/mem_Addr/mem_WriteData stay constant for all 7 cycles, with exactly one completion.
- Reset mid-op: Reset_n low while in BUSY -> mem_Req = 0 immediately. After release, all Busy = 0, no ReadReady, and a new request completes normally.
- ARB_FIXED_PRIO_EN defined: continuous requests on both ports -> port 1 always wins; port 0 is served only when port 1 is idle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-to-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } arb_state_e;

   localparam logic MEM_RD    = 1'b0;
   localparam logic MEM_WR    = 1'b1;
   localparam int   PORT_I    = 0;
   localparam int   PORT_D    = 1;
   localparam int   NUM_PORTS = 2;

   // With both ports pending the port other than `last` wins; a fixed-priority
   // build passes last = PORT_I so the D-cache always wins.
   function automatic logic pick_port(input logic [NUM_PORTS-1:0] pend, input logic last);
      if (&pend) return ~last;
      return pend[PORT_D];
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache request/response ports and the main-memory request bus of mem_arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p0_ReadValid,  p1_ReadValid;
   logic [ADDR_W-1:0] p0_ReadAddr,   p1_ReadAddr;
   logic              p0_WriteValid, p1_WriteValid;
   logic [ADDR_W-1:0] p0_WriteAddr,  p1_WriteAddr;
   logic [DATA_W-1:0] p0_WriteData,  p1_WriteData;
   logic              p0_ReadReady,  p1_ReadReady;
   logic [DATA_W-1:0] p0_ReadData,   p1_ReadData;
   logic              p0_Busy,       p1_Busy;
   logic              mem_Req;
   logic              mem_RW;
   logic [ADDR_W-1:0] mem_Addr;
   logic [DATA_W-1:0] mem_WriteData;
   logic              mem_Ack;
   logic [DATA_W-1:0] mem_ReadData;

   modport slave (
      input  p0_ReadValid, p0_ReadAddr, p0_WriteValid, p0_WriteAddr, p0_WriteData,
      input  p1_ReadValid, p1_ReadAddr, p1_WriteValid, p1_WriteAddr, p1_WriteData,
      output p0_ReadReady, p0_ReadData, p0_Busy,
      output p1_ReadReady, p1_ReadData, p1_Busy,
      output mem_Req, mem_RW, mem_Addr, mem_WriteData,
      input  mem_Ack, mem_ReadData
   );

   modport master (
      output p0_ReadValid, p0_ReadAddr, p0_WriteValid, p0_WriteAddr, p0_WriteData,
      output p1_ReadValid, p1_ReadAddr, p1_WriteValid, p1_WriteAddr, p1_WriteData,
      input  p0_ReadReady, p0_ReadData, p0_Busy,
      input  p1_ReadReady, p1_ReadData, p1_Busy,
      input  mem_Req, mem_RW, mem_Addr, mem_WriteData,
      output mem_Ack, mem_ReadData
   );
endinterface

// File: rtl/arb_req_slot.sv
// Per-port request slot: latches read/write pulses while idle and clears on
// the arbiter's grant+ack strobe.
module arb_req_slot #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr_in,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   input  logic              clr_rd,
   input  logic              clr_wr,
   output logic              rd_pend,
   output logic              wr_pend,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy
);
   logic              rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   assign busy = rd_pend_q | wr_pend_q;

   // Capture only happens with both slots empty, so it never meets a clear.
   always_comb begin
      rd_pend_d = rd_pend_q & ~clr_rd;
      wr_pend_d = wr_pend_q & ~clr_wr;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (!busy) begin
         if (rd_valid) begin
            rd_pend_d = 1'b1;
            rd_addr_d = rd_addr_in;
         end
         if (wr_valid) begin
            wr_pend_d = 1'b1;
            wr_addr_d = wr_addr_in;
            wr_data_d = wr_data_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_q <= 1'b0;
         wr_pend_q <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         rd_pend_q <= rd_pend_d;
         wr_pend_q <= wr_pend_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign rd_pend = rd_pend_q;
   assign wr_pend = wr_pend_q;
   assign rd_addr = rd_addr_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
endmodule

// File: rtl/mem_arbiter.sv
// I-cache / D-cache arbiter onto one single-ported memory, one transaction at a time.
// Define ARB_FIXED_PRIO_EN for fixed D-cache priority instead of round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          CLK,
   input  logic          Reset_n,
   mem_arbiter_if.slave  bus
);
   logic [NUM_PORTS-1:0]             rd_vld, wr_vld, rd_pend, wr_pend, busy, clr_rd, clr_wr, pend_any;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr_in, wr_addr_in, rd_addr, wr_addr;
   logic [NUM_PORTS-1:0][DATA_W-1:0] wr_data_in, wr_data;

   assign rd_vld     = {bus.p1_ReadValid,  bus.p0_ReadValid};
   assign wr_vld     = {bus.p1_WriteValid, bus.p0_WriteValid};
   assign rd_addr_in = {bus.p1_ReadAddr,   bus.p0_ReadAddr};
   assign wr_addr_in = {bus.p1_WriteAddr,  bus.p0_WriteAddr};
   assign wr_data_in = {bus.p1_WriteData,  bus.p0_WriteData};

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
      arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
         .clk        (CLK),
         .rst_n      (Reset_n),
         .rd_valid   (rd_vld[g]),
         .rd_addr_in (rd_addr_in[g]),
         .wr_valid   (wr_vld[g]),
         .wr_addr_in (wr_addr_in[g]),
         .wr_data_in (wr_data_in[g]),
         .clr_rd     (clr_rd[g]),
         .clr_wr     (clr_wr[g]),
         .rd_pend    (rd_pend[g]),
         .wr_pend    (wr_pend[g]),
         .rd_addr    (rd_addr[g]),
         .wr_addr    (wr_addr[g]),
         .wr_data    (wr_data[g]),
         .busy       (busy[g])
      );
   end

   arb_state_e                       state_q, state_d;
   logic                             gnt_port_q, gnt_port_d, sel_port, arb_last;
   logic                             mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]                mem_wdata_q, mem_wdata_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
   logic [NUM_PORTS-1:0]             rd_rdy_q, rd_rdy_d;

`ifdef ARB_FIXED_PRIO_EN
   assign arb_last = 1'b0;
`else
   logic last_grant_q, last_grant_d;
   assign arb_last = last_grant_q;
`endif

   assign pend_any = rd_pend | wr_pend;
   assign sel_port = pick_port(pend_any, arb_last);

   always_comb begin
      state_d     = state_q;
      gnt_port_d  = gnt_port_q;
      mem_req_d   = mem_req_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_data_d   = rd_data_q;
      rd_rdy_d    = '0;
      clr_rd      = '0;
      clr_wr      = '0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pend_any) begin
               gnt_port_d = sel_port;
               mem_req_d  = 1'b1;
               // Write before read within a port so a refill sees its own writeback.
               if (wr_pend[sel_port]) begin
                  mem_rw_d    = MEM_WR;
                  mem_addr_d  = wr_addr[sel_port];
                  mem_wdata_d = wr_data[sel_port];
               end else begin
                  mem_rw_d    = MEM_RD;
                  mem_addr_d  = rd_addr[sel_port];
                  mem_wdata_d = '0;
               end
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.mem_Ack) begin
               mem_req_d = 1'b0;
               if (mem_rw_q == MEM_WR) begin
                  clr_wr[gnt_port_q] = 1'b1;
               end else begin
                  clr_rd[gnt_port_q]    = 1'b1;
                  rd_data_d[gnt_port_q] = bus.mem_ReadData;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            rd_rdy_d[gnt_port_q] = (mem_rw_q == MEM_RD);
`ifndef ARB_FIXED_PRIO_EN
            last_grant_d = gnt_port_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         gnt_port_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_data_q   <= '0;
         rd_rdy_q    <= '0;
      end else begin
         state_q     <= state_d;
         gnt_port_q  <= gnt_port_d;
         mem_req_q   <= mem_req_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_data_q   <= rd_data_d;
         rd_rdy_q    <= rd_rdy_d;
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) last_grant_q <= 1'b0;
      else          last_grant_q <= last_grant_d;
   end
`endif

   assign bus.p0_ReadReady  = rd_rdy_q[PORT_I];
   assign bus.p1_ReadReady  = rd_rdy_q[PORT_D];
   assign bus.p0_ReadData   = rd_data_q[PORT_I];
   assign bus.p1_ReadData   = rd_data_q[PORT_D];
   assign bus.p0_Busy       = busy[PORT_I];
   assign bus.p1_Busy       = busy[PORT_D];
   assign bus.mem_Req       = mem_req_q;
   assign bus.mem_RW        = mem_rw_q;
   assign bus.mem_Addr      = mem_addr_q;
   assign bus.mem_WriteData = mem_wdata_q;
endmodule
